// File: rtl/fetch_stage.sv
// fetch_stage: PC register, IF/ID pipeline buffer and RUN/HALT fetch control.
// Optional macro FETCH_BR_FLUSH_EN: when defined, a taken branch squashes the
// wrong-path instruction (IF/ID loads a NOP); when undefined the fetched
// instruction is kept as a delay slot.
//
// state | meaning
// RUN   | normal fetch, PC advances by 2 unless stalled or redirected
// HALT  | HALT opcode seen; PC frozen, IF/ID drains to NOP, left only by reset
module fetch_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCwrite,
  input  logic        IF_ID_write,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic [15:0] instr_in,
  output logic [15:0] pc_out,
  output logic [15:0] IF_ID_instr,
  output logic [15:0] IF_ID_pc,
  output logic [3:0]  IF_ID_op1,
  output logic [3:0]  IF_ID_op2,
  output logic        IF_ID_valid,
  output logic        halted
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [3:0]  HALT_OP = 4'hF;
  localparam logic [15:0] NOP     = 16'h0000;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ifid_pc_q, ifid_pc_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [15:0] pc_plus2;
  logic        halt_fetch;

  assign pc_plus2   = pc_q + 16'd2;
  // A HALT only counts when it actually enters IF/ID and no redirect discards it.
  assign halt_fetch = (instr_in[15:12] == HALT_OP) && IF_ID_write && !br_taken;

  // Next-state, next-PC and IF/ID load selection.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    ifid_pc_d = ifid_pc_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    if (state_q == RUN) begin
      if (br_taken) begin
        pc_d = br_target;
`ifdef FETCH_BR_FLUSH_EN
        instr_d = NOP;
        valid_d = 1'b0;
`else
        instr_d   = instr_in;
        ifid_pc_d = pc_plus2;
        valid_d   = 1'b1;
`endif
      end else begin
        if (IF_ID_write) begin
          instr_d   = instr_in;
          ifid_pc_d = pc_plus2;
          valid_d   = 1'b1;
        end
        if (halt_fetch) begin
          // PC stays on the HALT address.
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (PCwrite) begin
          pc_d = pc_plus2;
        end
      end
    end else begin
      halted_d = 1'b1;
      if (IF_ID_write) begin
        instr_d = NOP;
        valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      pc_q      <= 16'h0000;
      instr_q   <= 16'h0000;
      ifid_pc_q <= 16'h0000;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      ifid_pc_q <= ifid_pc_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
    end
  end

  assign pc_out      = pc_q;
  assign IF_ID_instr = instr_q;
  assign IF_ID_pc    = ifid_pc_q;
  assign IF_ID_valid = valid_q;
  assign IF_ID_op1   = instr_q[11:8];
  assign IF_ID_op2   = instr_q[7:4];
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage (reset, sequencing, stall,
// redirect, wrap, HALT, reset priority).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCwrite;
  logic        IF_ID_write;
  logic        br_taken;
  logic [15:0] br_target;
  logic [15:0] instr_in;
  logic [15:0] pc_out;
  logic [15:0] IF_ID_instr;
  logic [15:0] IF_ID_pc;
  logic [3:0]  IF_ID_op1;
  logic [3:0]  IF_ID_op2;
  logic        IF_ID_valid;
  logic        halted;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCwrite     (PCwrite),
    .IF_ID_write (IF_ID_write),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .instr_in    (instr_in),
    .pc_out      (pc_out),
    .IF_ID_instr (IF_ID_instr),
    .IF_ID_pc    (IF_ID_pc),
    .IF_ID_op1   (IF_ID_op1),
    .IF_ID_op2   (IF_ID_op2),
    .IF_ID_valid (IF_ID_valid),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; PCwrite = 1'b1; IF_ID_write = 1'b1;
    br_taken = 1'b0; br_target = 16'h0000; instr_in = 16'h1230;
    #2;
    step();
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_instr", IF_ID_instr, 16'h0000);
    chk("rst_ifpc", IF_ID_pc, 16'h0000);
    chk("rst_valid", {15'd0, IF_ID_valid}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);

    // free-running fetch
    rst_n = 1'b1;
    step();
    chk("run1_pc", pc_out, 16'h0002);
    chk("run1_ifpc", IF_ID_pc, 16'h0002);
    chk("run1_instr", IF_ID_instr, 16'h1230);
    chk("run1_op1", {12'd0, IF_ID_op1}, 16'h0002);
    chk("run1_op2", {12'd0, IF_ID_op2}, 16'h0003);
    chk("run1_valid", {15'd0, IF_ID_valid}, 16'd1);
    step();
    chk("run2_pc", pc_out, 16'h0004);
    chk("run2_ifpc", IF_ID_pc, 16'h0004);
    step();
    chk("run3_pc", pc_out, 16'h0006);
    chk("run3_ifpc", IF_ID_pc, 16'h0006);
    step();
    chk("run4_pc", pc_out, 16'h0008);

    // two-cycle stall at 0x0008
    PCwrite = 1'b0; IF_ID_write = 1'b0; instr_in = 16'h1450;
    step();
    chk("stall1_pc", pc_out, 16'h0008);
    chk("stall1_instr", IF_ID_instr, 16'h1230);
    chk("stall1_ifpc", IF_ID_pc, 16'h0008);
    step();
    chk("stall2_pc", pc_out, 16'h0008);
    chk("stall2_instr", IF_ID_instr, 16'h1230);
    PCwrite = 1'b1; IF_ID_write = 1'b1;
    step();
    chk("resume_pc", pc_out, 16'h000A);
    chk("resume_instr", IF_ID_instr, 16'h1450);
    chk("resume_ifpc", IF_ID_pc, 16'h000A);

    // redirect during stall at pc 0x000A
    PCwrite = 1'b0; IF_ID_write = 1'b0; br_taken = 1'b1;
    br_target = 16'h0040; instr_in = 16'h5670;
    step();
    chk("br_pc", pc_out, 16'h0040);
`ifdef FETCH_BR_FLUSH_EN
    chk("br_valid", {15'd0, IF_ID_valid}, 16'd0);
    chk("br_instr", IF_ID_instr, 16'h0000);
`else
    chk("br_valid", {15'd0, IF_ID_valid}, 16'd1);
    chk("br_instr", IF_ID_instr, 16'h5670);
    chk("br_ifpc", IF_ID_pc, 16'h000C);
`endif
    PCwrite = 1'b1; IF_ID_write = 1'b1;

    // wrap at top of address space
    br_target = 16'hFFFC; instr_in = 16'h2000;
    step();
    chk("wrap0_pc", pc_out, 16'hFFFC);
    br_taken = 1'b0;
    step();
    chk("wrap1_pc", pc_out, 16'hFFFE);
    chk("wrap1_ifpc", IF_ID_pc, 16'hFFFE);
    step();
    chk("wrap2_pc", pc_out, 16'h0000);
    chk("wrap2_ifpc", IF_ID_pc, 16'h0000);

    // go to 0x0010; first a HALT that coincides with a redirect is discarded
    br_taken = 1'b1; br_target = 16'h0010; instr_in = 16'h1111;
    step();
    chk("to10_pc", pc_out, 16'h0010);
    instr_in = 16'hF000;
    step();
    chk("halt_br_discard", {15'd0, halted}, 16'd0);
    chk("halt_br_pc", pc_out, 16'h0010);

    // real HALT at 0x0010
    br_taken = 1'b0;
    step();
    chk("halt_halted", {15'd0, halted}, 16'd1);
    chk("halt_pc", pc_out, 16'h0010);
    chk("halt_instr", IF_ID_instr, 16'hF000);
    chk("halt_ifpc", IF_ID_pc, 16'h0012);
    chk("halt_valid", {15'd0, IF_ID_valid}, 16'd1);
    instr_in = 16'h3330;
    step();
    chk("halt_nop_valid", {15'd0, IF_ID_valid}, 16'd0);
    chk("halt_nop_instr", IF_ID_instr, 16'h0000);
    chk("halt_hold_pc", pc_out, 16'h0010);
    br_taken = 1'b1; br_target = 16'h0080;
    step();
    chk("halt_br_ign_pc", pc_out, 16'h0010);
    chk("halt_br_ign_halted", {15'd0, halted}, 16'd1);
    br_taken = 1'b0;

    // reset while halted
    rst_n = 1'b0; PCwrite = 1'b0; IF_ID_write = 1'b0;
    step();
    chk("rsth_pc", pc_out, 16'h0000);
    chk("rsth_halted", {15'd0, halted}, 16'd0);
    chk("rsth_instr", IF_ID_instr, 16'h0000);
    chk("rsth_ifpc", IF_ID_pc, 16'h0000);
    rst_n = 1'b1; PCwrite = 1'b1; IF_ID_write = 1'b1; instr_in = 16'h1230;
    step();
    chk("rsth_restart_pc", pc_out, 16'h0002);
    chk("rsth_restart_valid", {15'd0, IF_ID_valid}, 16'd1);
    step();
    chk("pre_stall_pc", pc_out, 16'h0004);

    // reset while stalled
    PCwrite = 1'b0; IF_ID_write = 1'b0; rst_n = 1'b0;
    step();
    chk("rsts_pc", pc_out, 16'h0000);
    chk("rsts_valid", {15'd0, IF_ID_valid}, 16'd0);
    chk("rsts_ifpc", IF_ID_pc, 16'h0000);
    rst_n = 1'b1; PCwrite = 1'b1; IF_ID_write = 1'b1;
    step();
    chk("rsts_restart_pc", pc_out, 16'h0002);
    chk("rsts_restart_ifpc", IF_ID_pc, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
